// File: rtl/decoder_scan_seq.sv
// Select sequencer for a 3-to-8 one-hot decoder: steps a registered channel code
// through the enabled channels of a latched mask, holding each for a programmable dwell.
module decoder_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               active,
  output logic               busy,
  output logic               pass_done
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t             state, state_nx;
  logic [7:0]         mask_q, mask_nx;
  logic               mode_q, mode_nx;
  logic [DWELL_W-1:0] dwell_q, dwell_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic [2:0]         sel_nx;
  logic               active_nx, busy_nx, pass_done_nx;

  logic [2:0]         first_in, first_sh, higher_idx;
  logic               higher_ok;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) idx = 3'(i);
    return idx;
  endfunction

  // Hold count for a given dwell: a dwell of 0 behaves like 1.
  function automatic logic [DWELL_W-1:0] reload(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  always_comb begin
    first_in   = lowest_set(ch_mask);
    first_sh   = lowest_set(mask_q);
    higher_ok  = 1'b0;
    higher_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (3'(i) > sel)) begin
        higher_ok  = 1'b1;
        higher_idx = 3'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nx     = state;
    mask_nx      = mask_q;
    mode_nx      = mode_q;
    dwell_nx     = dwell_q;
    cnt_nx       = cnt;
    sel_nx       = sel;
    active_nx    = active;
    busy_nx      = busy;
    pass_done_nx = 1'b0;

    if (stop) begin
      state_nx  = IDLE;
      sel_nx    = '0;
      active_nx = 1'b0;
      busy_nx   = 1'b0;
      cnt_nx    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && (ch_mask != 8'h00)) begin
            mask_nx   = ch_mask;
            mode_nx   = mode;
            dwell_nx  = dwell;
            sel_nx    = first_in;
            active_nx = 1'b1;
            busy_nx   = 1'b1;
            cnt_nx    = reload(dwell);
            state_nx  = DWELL;
          end
        end
        DWELL: begin
          if (cnt != '0) begin
            cnt_nx = cnt - DWELL_W'(1);
          end else if (higher_ok) begin
            sel_nx = higher_idx;
            cnt_nx = reload(dwell_q);
          end else if (mode_q) begin
            sel_nx       = first_sh;
            cnt_nx       = reload(dwell_q);
            pass_done_nx = 1'b1;
          end else begin
            state_nx     = IDLE;
            sel_nx       = '0;
            active_nx    = 1'b0;
            busy_nx      = 1'b0;
            pass_done_nx = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask_q    <= '0;
      mode_q    <= 1'b0;
      dwell_q   <= '0;
      cnt       <= '0;
      sel       <= '0;
      active    <= 1'b0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
    end else begin
      state     <= state_nx;
      mask_q    <= mask_nx;
      mode_q    <= mode_nx;
      dwell_q   <= dwell_nx;
      cnt       <= cnt_nx;
      sel       <= sel_nx;
      active    <= active_nx;
      busy      <= busy_nx;
      pass_done <= pass_done_nx;
    end
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: directed scenarios plus random traffic, all checked
// against a queue-based model that expands each pass into its per-cycle channel list.
module tb_decoder_scan_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [7:0] ch_mask = '0;
  logic [7:0] dwell = '0;
  logic [2:0] sel;
  logic       active, busy, pass_done;

  int checks = 0;
  int errors = 0;

  decoder_scan_seq #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .ch_mask(ch_mask), .dwell(dwell), .sel(sel), .active(active),
    .busy(busy), .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  // Reference model: one queue entry per future cycle of the current pass.
  logic [2:0] q[$];
  bit         running = 0;
  bit         m_mode = 0;
  logic [7:0] m_mask = '0;
  int         m_dw = 1;
  logic [2:0] e_sel = '0;
  bit         e_act = 0, e_busy = 0, e_pd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_pass();
    for (int k = 0; k < 8; k++)
      if (m_mask[k])
        for (int r = 0; r < m_dw; r++) q.push_back(3'(k));
  endtask

  task automatic model_idle();
    running = 0;
    q.delete();
    e_sel = '0; e_act = 0; e_busy = 0;
  endtask

  task automatic model_edge();
    e_pd = 0;
    if (!rst_n) begin
      model_idle();
    end else if (stop) begin
      model_idle();
    end else if (!running) begin
      if (start && ch_mask != 8'h00) begin
        m_mask = ch_mask; m_mode = mode; m_dw = (dwell == 0) ? 1 : int'(dwell);
        build_pass();
        e_sel = q.pop_front(); e_act = 1; e_busy = 1; running = 1;
      end
    end else if (q.size() > 0) begin
      e_sel = q.pop_front();
    end else begin
      e_pd = 1;
      if (m_mode) begin
        build_pass();
        e_sel = q.pop_front();
      end else begin
        model_idle();
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("sel", 32'(sel), 32'(e_sel));
    check("active", 32'(active), 32'(e_act));
    check("busy", 32'(busy), 32'(e_busy));
    check("pass_done", 32'(pass_done), 32'(e_pd));
  endtask

  task automatic launch(input logic [7:0] m, input logic [7:0] d, input logic md);
    ch_mask = m; dwell = d; mode = md; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  logic [2:0] t2_tab [10];
  int pd_count;

  initial begin
    t2_tab = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7, 3'd2};
    #1;
    check("rst_sel", 32'(sel), 0);
    check("rst_active", 32'(active), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pd", 32'(pass_done), 0);
    #12 rst_n = 1'b1;
    repeat (2) cycle();

    // Full mask, dwell 1, single pass.
    launch(8'hFF, 8'd1, 1'b0);
    check("t1_first", 32'(sel), 0);
    repeat (9) cycle();

    // Sparse mask, dwell 3, continuous; compare against the literal sequence too.
    launch(8'b1010_0100, 8'd3, 1'b1);
    check("t2_seq0", 32'(sel), 32'(t2_tab[0]));
    pd_count = 0;
    for (int i = 1; i < 10; i++) begin
      cycle();
      check("t2_seq", 32'(sel), 32'(t2_tab[i]));
      if (pass_done) pd_count++;
    end
    check("t2_pd_once", pd_count, 1);
    // Run until sel=5, then stop.
    for (int i = 0; i < 20 && sel != 3'd5; i++) cycle();
    check("t4_at5", 32'(sel), 5);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("t4_stopped", 32'(busy), 0);
    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1; ch_mask = 8'h0F;
    cycle();
    start = 1'b0; stop = 1'b0;
    check("t4_both", 32'(busy), 0);

    // Dwell 0 treated as 1, endpoints only.
    launch(8'h81, 8'd0, 1'b0);
    repeat (3) cycle();

    // Empty mask ignored.
    launch(8'h00, 8'd2, 1'b1);
    check("t5_empty", 32'(active), 0);
    cycle();

    // Mid-scan changes and repeated start must not disturb the sequence.
    launch(8'b0001_0010, 8'd2, 1'b0);
    ch_mask = 8'hFF; dwell = 8'd7; mode = 1'b1; start = 1'b1;
    repeat (3) cycle();
    start = 1'b0;
    repeat (3) cycle();

    // Single-bit continuous: pass_done every dwell cycles.
    launch(8'h08, 8'd2, 1'b1);
    repeat (7) cycle();
    stop = 1'b1; cycle(); stop = 1'b0;

    // Asynchronous reset mid-dwell.
    launch(8'h30, 8'd5, 1'b1);
    repeat (2) cycle();
    #3 rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(sel), 0);
    check("arst_active", 32'(active), 0);
    check("arst_busy", 32'(busy), 0);
    model_idle();
    cycle();
    #2 rst_n = 1'b1;
    launch(8'h30, 8'd1, 1'b0);
    check("arst_restart", 32'(sel), 4);
    repeat (3) cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 60) == 0);
      mode    = 1'($urandom_range(0, 1));
      ch_mask = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      dwell   = 8'($urandom_range(0, 4));
      cycle();
    end
    start = 1'b0; stop = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
